// File: rtl/bp_fifo_1r1w_ready_yumi.sv
// bp_fifo_1r1w_ready_yumi: ready/valid-in, valid/yumi-out FIFO controller
// around a synthesized 1r1w storage array (els_p must be a power of two, >= 2).
// Optional macro BP_FIFO_OCCUPANCY_EN adds the count_o occupancy output.
module bp_fifo_1r1w_ready_yumi #(
    parameter int unsigned width_p = 109,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
`ifdef BP_FIFO_OCCUPANCY_EN
    output logic [$clog2(els_p+1)-1:0] count_o,
`endif
    input  logic               yumi_i
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned pw_lp        = ptr_width_lp + 1;

    logic [pw_lp-1:0]   wptr_q, wptr_d;
    logic [pw_lp-1:0]   rptr_q, rptr_d;
    logic [width_p-1:0] mem_q [els_p];

    logic empty_c, full_c, enq_c, deq_c;

    // Status flags; the extra pointer MSB distinguishes full from empty.
    always_comb begin
        empty_c = (wptr_q == rptr_q);
        full_c  = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
               && (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]);
        ready_o = ~full_c & ~reset_i;
        v_o     = ~empty_c;
        enq_c   = v_i & ready_o;
        deq_c   = yumi_i & v_o;
        data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];
    end

    // Next-state pointers: modulo 2^(ptr_width_lp+1) increments.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (enq_c) wptr_d = wptr_q + pw_lp'(1);
        if (deq_c) rptr_d = rptr_q + pw_lp'(1);
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (enq_c) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
    end

`ifdef BP_FIFO_OCCUPANCY_EN
    // Occupancy is the modular pointer distance.
    always_comb begin
        count_o = $clog2(els_p+1)'(wptr_q - rptr_q);
    end
`endif

`ifndef SYNTHESIS
    // Protocol checks on the handshake inputs.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!$isunknown({v_i, yumi_i}))
                else $error("unknown value on v_i/yumi_i");
            assert (!(yumi_i === 1'b1 && v_o === 1'b0))
                else $warning("yumi_i asserted while empty; read pointer held");
        end
    end
`endif

endmodule

// File: tb/tb_bp_fifo_1r1w_ready_yumi.sv
// Self-checking bench for bp_fifo_1r1w_ready_yumi: directed vector table,
// reset corner sequences and randomized traffic against a queue model.
module tb_bp_fifo_1r1w_ready_yumi;

    localparam int unsigned W   = 109;
    localparam int unsigned ELS = 2;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         v_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         yumi_i = 1'b0;
    logic         ready_o, v_o;
    logic [W-1:0] data_o;
`ifdef BP_FIFO_OCCUPANCY_EN
    logic [1:0]   count_o;
`endif

    int checks = 0;
    int errors = 0;

    bp_fifo_1r1w_ready_yumi #(.width_p(W), .els_p(ELS)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
`ifdef BP_FIFO_OCCUPANCY_EN
        .count_o (count_o),
`endif
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         y;
        logic         exp_ready;
        logic         exp_v;
        logic [W-1:0] exp_data;
        int           exp_count;
    } vec_t;

    vec_t vecs [13];
    logic [W-1:0] model_q [$];

    // Model-based output check before the edge, model update on the edge.
    task automatic model_cycle(input logic v, input logic [W-1:0] d, input logic y, input string tag);
        int sz;
        @(negedge clk_i);
        v_i = v; data_i = d; yumi_i = y;
        #1;
        sz = model_q.size();
        chk({tag, "_ready"}, 128'(ready_o), 128'(sz < ELS));
        chk({tag, "_v"}, 128'(v_o), 128'(sz > 0));
        if (sz > 0) chk({tag, "_data"}, 128'(data_o), 128'(model_q[0]));
`ifdef BP_FIFO_OCCUPANCY_EN
        chk({tag, "_count"}, 128'(count_o), 128'(sz));
`endif
        @(posedge clk_i);
        if (y && sz > 0) void'(model_q.pop_front());
        if (v && sz < ELS) model_q.push_back(d);
    endtask

    initial begin
        int sent, recvd, cyc, sz;
        logic v, y;
        logic [W-1:0] d, head;

        // inputs: v, d, y ; expected after edge: ready, v, data, count
        vecs[0]  = '{1'b1, W'('h1A5), 1'b0, 1'b1, 1'b1, W'('h1A5), 1};
        vecs[1]  = '{1'b0, W'(0),     1'b1, 1'b1, 1'b0, W'(0),     0};
        vecs[2]  = '{1'b1, W'('h1),   1'b0, 1'b1, 1'b1, W'('h1),   1};
        vecs[3]  = '{1'b1, W'('h2),   1'b0, 1'b0, 1'b1, W'('h1),   2};
        vecs[4]  = '{1'b1, W'('h3),   1'b0, 1'b0, 1'b1, W'('h1),   2};
        vecs[5]  = '{1'b0, W'(0),     1'b1, 1'b1, 1'b1, W'('h2),   1};
        vecs[6]  = '{1'b0, W'(0),     1'b1, 1'b1, 1'b0, W'(0),     0};
        vecs[7]  = '{1'b1, W'('hAA),  1'b0, 1'b1, 1'b1, W'('hAA),  1};
        vecs[8]  = '{1'b1, W'('hBB),  1'b1, 1'b1, 1'b1, W'('hBB),  1};
        vecs[9]  = '{1'b0, W'(0),     1'b1, 1'b1, 1'b0, W'(0),     0};
        vecs[10] = '{1'b0, W'(0),     1'b1, 1'b1, 1'b0, W'(0),     0};
        vecs[11] = '{1'b1, W'('h7),   1'b0, 1'b1, 1'b1, W'('h7),   1};
        vecs[12] = '{1'b0, W'(0),     1'b1, 1'b1, 1'b0, W'(0),     0};

        // Asynchronous reset asserted mid-cycle.
        @(posedge clk_i);
        #3 reset_i = 1'b1;
        #1;
        chk("rst_v", 128'(v_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rel_ready", 128'(ready_o), 128'(1));
        chk("rel_v", 128'(v_o), 128'(0));

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            v_i = vecs[i].v; data_i = vecs[i].d; yumi_i = vecs[i].y;
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_ready", i), 128'(ready_o), 128'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_v", i), 128'(v_o), 128'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk($sformatf("vec%0d_data", i), 128'(data_o), 128'(vecs[i].exp_data));
`ifdef BP_FIFO_OCCUPANCY_EN
            chk($sformatf("vec%0d_count", i), 128'(count_o), 128'(vecs[i].exp_count));
`endif
        end

        // Reset while full, between edges.
        @(negedge clk_i); v_i = 1'b1; data_i = W'('h55); yumi_i = 1'b0;
        @(negedge clk_i); data_i = W'('h66);
        @(negedge clk_i); v_i = 1'b0;
        #1;
        chk("full_ready", 128'(ready_o), 128'(0));
        chk("full_data", 128'(data_o), 128'('h55));
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_v", 128'(v_o), 128'(0));
        chk("midrst_ready", 128'(ready_o), 128'(0));
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("midrel_v", 128'(v_o), 128'(0));
        chk("midrel_ready", 128'(ready_o), 128'(1));
        @(posedge clk_i);
        #1;
        chk("midrel_stay_empty", 128'(v_o), 128'(0));
        model_q.delete();

        // Stream 0..9 with random 50% yumi; order must be preserved.
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 10 && cyc < 200) begin
            sz = model_q.size();
            head = (sz > 0) ? model_q[0] : '0;
            v = (sent < 10);
            y = (sz > 0) && ($urandom_range(1, 0) == 1);
            model_cycle(v, W'(sent), y, "stream");
            if (v && sz < ELS) sent++;
            if (y) begin
                chk("stream_order", 128'(head), 128'(recvd));
                recvd++;
            end
            cyc++;
        end
        chk("stream_done", 128'(recvd), 128'(10));

        // Randomized traffic with legal yumi only.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(3, 0) != 0);
            d = W'({$urandom, $urandom, $urandom, $urandom});
            y = (model_q.size() > 0) && ($urandom_range(1, 0) == 1);
            model_cycle(v, d, y, "rand");
        end

        @(negedge clk_i);
        v_i = 1'b0; yumi_i = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
